// File: rtl/exe_mem_stage_reg_pkg.sv
// Shared widths and payload type for the EXE->MEM pipeline register.
package exe_mem_stage_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TAG_W  = 4;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data_b;
    logic [REG_W-1:0]  dest;
    logic [TAG_W-1:0]  ins_type;
    logic [TAG_W-1:0]  ins_number;
  } exe_mem_payload;

  // Only the write enables are qualified; data of a bubble passes through.
  function automatic exe_mem_payload qualify(input exe_mem_payload p, input logic v);
    exe_mem_payload r;
    r      = p;
    r.wreg = p.wreg & v;
    r.wmem = p.wmem & v;
    return r;
  endfunction

endpackage

// File: rtl/exe_mem_skid_buf.sv
// One-entry skid buffer catching an EXE payload accepted while MEM stalls.
// Present only when EXE_MEM_SKID_EN is defined.
`ifdef EXE_MEM_SKID_EN
module exe_mem_skid_buf
  import exe_mem_stage_reg_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  input  exe_mem_payload in_pl,
  input  logic           out_valid,
  input  logic           out_ready,
  output logic           in_ready,
  output logic           skid_valid,
  output exe_mem_payload skid_pl
);

  logic stall;
  logic capture;

  assign stall   = out_valid && !out_ready;
  assign capture = !skid_valid && in_valid && stall;

  // in_ready is kept as its own flop, always the inverse of skid_valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (capture) begin
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end else if (skid_valid && !stall) begin
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      skid_pl <= in_pl;
    end
  end

endmodule
`endif

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, flush and bubble gating.
// Define EXE_MEM_SKID_EN to add a 1-entry skid buffer with a registered in_ready.
module exe_mem_stage_reg
  import exe_mem_stage_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic                ewreg,
  input  logic                em2reg,
  input  logic                ewmem,
  input  logic [DATA_W-1:0]   ealu,
  input  logic [DATA_W-1:0]   edata_b,
  input  logic [REG_W-1:0]    ex_destR,
  input  logic [TAG_W-1:0]    EXE_ins_type,
  input  logic [TAG_W-1:0]    EXE_ins_number,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                mwreg,
  output logic                mm2reg,
  output logic                mwmem,
  output logic [DATA_W-1:0]   malu,
  output logic [DATA_W-1:0]   mdata_b,
  output logic [REG_W-1:0]    mem_destR,
  output logic [TAG_W-1:0]    MEM_ins_type,
  output logic [TAG_W-1:0]    MEM_ins_number
);

  exe_mem_payload in_pl;
  exe_mem_payload out_pl;
  exe_mem_payload load_pl;
  logic           load_en;
  logic           load_valid;

  always_comb begin
    in_pl            = '0;
    in_pl.wreg       = ewreg;
    in_pl.m2reg      = em2reg;
    in_pl.wmem       = ewmem;
    in_pl.alu        = ealu;
    in_pl.data_b     = edata_b;
    in_pl.dest       = ex_destR;
    in_pl.ins_type   = EXE_ins_type;
    in_pl.ins_number = EXE_ins_number;
  end

`ifdef EXE_MEM_SKID_EN
  logic           skid_valid;
  exe_mem_payload skid_pl;

  exe_mem_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pl      (in_pl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .skid_valid (skid_valid),
    .skid_pl    (skid_pl)
  );

  // A held skid entry always goes to the output before any new input.
  always_comb begin
    load_en    = out_ready || !out_valid;
    load_pl    = in_pl;
    load_valid = in_valid && in_ready;
    if (skid_valid) begin
      load_pl    = skid_pl;
      load_valid = 1'b1;
    end
  end
`else
  assign in_ready = out_ready || !out_valid;

  always_comb begin
    load_en    = in_ready;
    load_pl    = in_pl;
    load_valid = in_valid;
  end
`endif

  // Output register: reset beats flush, flush beats load and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pl    <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_pl.wreg <= 1'b0;
      out_pl.wmem <= 1'b0;
    end else if (load_en) begin
      out_valid <= load_valid;
      out_pl    <= qualify(load_pl, load_valid);
    end
  end

  assign mwreg          = out_pl.wreg;
  assign mm2reg         = out_pl.m2reg;
  assign mwmem          = out_pl.wmem;
  assign malu           = out_pl.alu;
  assign mdata_b        = out_pl.data_b;
  assign mem_destR      = out_pl.dest;
  assign MEM_ins_type   = out_pl.ins_type;
  assign MEM_ins_number = out_pl.ins_number;

endmodule
